// File: rtl/single_fetch_unit.sv
// Instruction-fetch front end: holds the PC, issues one imem read per instruction, presents it with a valid flag.
// Latency: req rises 1 cycle after reset release or retire; o_instr_valid rises the cycle after the ack edge.
// Backpressure: i_stall holds the presented instruction and PC; a withheld ack holds req and the address stable.
module single_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic [1:0]  i_pc_sel,
    input  logic [31:0] i_branch_off,
    input  logic [25:0] i_jump_idx,
    input  logic [31:0] i_jr_addr,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_instr,
    output logic        o_instr_valid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        req_q, req_d;
    logic        vld_q, vld_d;
    logic [31:0] pc_plus4;
    logic [31:0] br_off_sh;
    logic [31:0] next_pc;

    // PC+4 wraps naturally in 32 bits; the branch offset is a word offset
    assign pc_plus4  = pc_q + 32'd4;
    assign br_off_sh = i_branch_off << 2;

    // Next-PC source mux; only consumed at the retire edge
    always_comb begin
        next_pc = pc_plus4;
        case (i_pc_sel)
            2'b01:   next_pc = pc_plus4 + br_off_sh;
            2'b10:   next_pc = {pc_plus4[31:28], i_jump_idx, 2'b00};
            2'b11:   next_pc = i_jr_addr & ~32'd3;
            default: next_pc = pc_plus4;
        endcase
    end

    // Fetch FSM next-state; req/valid are decoded from the next state so they come out of flops
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (i_imem_ack) begin
                    instr_d = i_imem_data;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (!i_stall) begin
                    pc_d    = next_pc;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
        req_d = (state_d == S_REQ);
        vld_d = (state_d == S_VALID);
    end

    // State and registered outputs; reset aborts any outstanding request immediately
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            req_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            vld_q   <= vld_d;
        end
    end

    assign o_imem_req    = req_q;
    assign o_imem_addr   = pc_q;
    assign o_pc          = pc_q;
    assign o_pc_plus4    = pc_plus4;
    assign o_instr       = instr_q;
    assign o_instr_valid = vld_q;

endmodule

// File: tb/tb_single_fetch_unit.sv
// Testbench for single_fetch_unit: directed fetch sequence with a scoreboard of expected (addr, instr) pairs.
// Driver plays the instruction memory and the datapath; monitor checks every cycle on the falling edge.
// Covers reset, sequential run, redirects, wait states, stalls, PC wrap and reset during an outstanding request.
module tb_single_fetch_unit;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_stall;
    logic [1:0]  i_pc_sel;
    logic [31:0] i_branch_off;
    logic [25:0] i_jump_idx;
    logic [31:0] i_jr_addr;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_data;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic [31:0] o_instr;
    logic        o_instr_valid;

    single_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_stall      (i_stall),
        .i_pc_sel     (i_pc_sel),
        .i_branch_off (i_branch_off),
        .i_jump_idx   (i_jump_idx),
        .i_jr_addr    (i_jr_addr),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_ack   (i_imem_ack),
        .i_imem_data  (i_imem_data),
        .o_pc         (o_pc),
        .o_pc_plus4   (o_pc_plus4),
        .o_instr      (o_instr),
        .o_instr_valid(o_instr_valid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    // Written only by the driver; the monitor walks it with its own read pointer
    exp_t exp_q[$];
    logic done;

    // ---------------- monitor / scoreboard ----------------
    int          total;
    int          bad;
    int          rd_ptr;
    logic        prev_rst, prev_idle, prev_req, prev_ack, prev_vld, prev_stall;
    logic [31:0] held_addr, held_pc, held_instr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    initial begin
        total = 0; bad = 0; rd_ptr = 0;
        prev_rst = 1'b1; prev_idle = 1'b0; prev_req = 1'b0;
        prev_ack = 1'b0; prev_vld = 1'b0; prev_stall = 1'b0;
        held_addr = 32'd0; held_pc = 32'd0; held_instr = 32'd0;
    end

    always @(negedge i_clk) begin
        if (done) begin
            check("scoreboard_drained", 32'(exp_q.size() - rd_ptr), 32'd0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end else if (!i_rst_n) begin
            // Anything queued before reset belongs to an aborted fetch
            rd_ptr = exp_q.size();
            check("rst_req",    32'(o_imem_req),    32'd0);
            check("rst_valid",  32'(o_instr_valid), 32'd0);
            check("rst_pc",     o_pc,               32'h0000_0000);
            check("rst_addr",   o_imem_addr,        32'h0000_0000);
            check("rst_plus4",  o_pc_plus4,         32'h0000_0004);
            check("rst_instr",  o_instr,            32'd0);
            prev_rst = 1'b1; prev_idle = 1'b0; prev_req = 1'b0;
            prev_ack = 1'b0; prev_vld = 1'b0; prev_stall = 1'b0;
        end else begin
            check("addr_is_pc", o_imem_addr, o_pc);
            check("pc_plus4",   o_pc_plus4,  o_pc + 32'd4);
            if (prev_rst)
                check("idle_after_release", 32'({o_imem_req, o_instr_valid}), 32'd0);
            else if (prev_idle)
                check("req_after_idle", 32'(o_imem_req), 32'd1);
            if (prev_req && prev_ack)
                check("valid_after_ack", 32'(o_instr_valid), 32'd1);
            if (prev_req && !prev_ack) begin
                check("req_held", 32'(o_imem_req), 32'd1);
                check("addr_stable", o_imem_addr, held_addr);
            end
            if (prev_vld && prev_stall)
                check("valid_held_in_stall", 32'(o_instr_valid), 32'd1);
            if (prev_vld && !prev_stall)
                check("req_after_retire", 32'({o_imem_req, o_instr_valid}), 32'd2);
            if (o_imem_req) begin
                if (rd_ptr >= exp_q.size()) begin
                    total++; bad++;
                    $display("FAIL unexpected_req: got addr %h expected no request", o_imem_addr);
                end else begin
                    check("fetch_addr", o_imem_addr, exp_q[rd_ptr].addr);
                end
                held_addr = o_imem_addr;
            end
            if (o_instr_valid) begin
                if (!prev_vld) begin
                    if (rd_ptr >= exp_q.size()) begin
                        total++; bad++;
                        $display("FAIL unexpected_valid: got instr %h expected no valid", o_instr);
                    end else begin
                        check("instr", o_instr, exp_q[rd_ptr].data);
                        check("instr_pc", o_pc, exp_q[rd_ptr].addr);
                        rd_ptr++;
                    end
                end else begin
                    check("instr_hold", o_instr, held_instr);
                    check("pc_hold", o_pc, held_pc);
                end
                held_instr = o_instr;
                held_pc    = o_pc;
            end
            prev_rst   = 1'b0;
            prev_idle  = !o_imem_req && !o_instr_valid;
            prev_req   = o_imem_req;
            prev_ack   = i_imem_ack;
            prev_vld   = o_instr_valid;
            prev_stall = i_stall;
        end
    end

    // ---------------- driver (memory + datapath) ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One instruction: wait for req, ack after `waits` idle req cycles, stall `stalls` cycles, then retire
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data,
                             input int waits, input int stalls,
                             input logic [1:0] sel, input logic [31:0] off,
                             input logic [25:0] idx, input logic [31:0] jr);
        int n;
        exp_q.push_back('{addr, data});
        n = 0;
        while (!o_imem_req) begin
            tick();
            n++;
            if (n > 20) begin
                $display("FAIL req_timeout: got no request expected req for addr %h", addr);
                $fatal(1);
            end
        end
        // stall has no meaning while a request is outstanding
        i_stall     = (waits > 0);
        i_imem_ack  = 1'b0;
        i_imem_data = 32'hDEAD_BEEF;
        repeat (waits) tick();
        i_imem_ack  = 1'b1;
        i_imem_data = data;
        tick();
        for (int s = 0; s < stalls; s++) begin
            // garbage selectors and a stray ack while stalled must not matter
            i_stall      = 1'b1;
            i_imem_ack   = 1'b1;
            i_imem_data  = 32'hBAD0_0000 | 32'(s);
            i_pc_sel     = ~sel;
            i_branch_off = ~off;
            i_jump_idx   = ~idx;
            i_jr_addr    = ~jr;
            tick();
        end
        i_stall      = 1'b0;
        i_imem_ack   = 1'b0;
        i_pc_sel     = sel;
        i_branch_off = off;
        i_jump_idx   = idx;
        i_jr_addr    = jr;
        tick();
        i_pc_sel     = 2'b11;
        i_branch_off = 32'h5555_5555;
        i_jump_idx   = 26'h2AA_AAAA;
        i_jr_addr    = 32'h7777_7777;
        i_imem_data  = 32'hDEAD_BEEF;
    endtask

    initial begin
        done         = 1'b0;
        i_rst_n      = 1'b0;
        i_stall      = 1'b0;
        i_pc_sel     = 2'b00;
        i_branch_off = 32'd0;
        i_jump_idx   = 26'd0;
        i_jr_addr    = 32'd0;
        i_imem_ack   = 1'b0;
        i_imem_data  = 32'd0;
        repeat (3) tick();
        i_rst_n = 1'b1;

        // reset and sequential run, zero-wait memory
        fetch_one(32'h0000_0000, 32'h2008_0005, 0, 0, 2'b00, 32'd0, 26'd0, 32'd0);
        fetch_one(32'h0000_0004, 32'h2009_0001, 0, 0, 2'b00, 32'd0, 26'd0, 32'd0);
        fetch_one(32'h0000_0008, 32'h012A_5820, 0, 0, 2'b00, 32'd0, 26'd0, 32'd0);
        fetch_one(32'h0000_000C, 32'hAC0B_0000, 0, 0, 2'b00, 32'd0, 26'd0, 32'd0);
        // backward branch: 0x14 - 8 = 0x0C
        fetch_one(32'h0000_0010, 32'h1000_FFFE, 0, 0, 2'b01, 32'hFFFF_FFFE, 26'd0, 32'd0);
        // jr to 0x9000_0000
        fetch_one(32'h0000_000C, 32'h0200_0008, 0, 0, 2'b11, 32'd0, 26'd0, 32'h9000_0000);
        // jump keeps top nibble of pc+4: 0x9000_0100
        fetch_one(32'h9000_0000, 32'h0800_0040, 0, 0, 2'b10, 32'd0, 26'h000_0040, 32'd0);
        // 3 wait states, 2 stall cycles, then jr 0x207 -> 0x204
        fetch_one(32'h9000_0100, 32'h00E0_0008, 3, 2, 2'b11, 32'd0, 26'd0, 32'h0000_0207);
        // forward branch: 0x208 + 0x40 = 0x248
        fetch_one(32'h0000_0204, 32'h1000_0010, 0, 0, 2'b01, 32'h0000_0010, 26'd0, 32'd0);
        // jr 0xFFFF_FFFF -> 0xFFFF_FFFC
        fetch_one(32'h0000_0248, 32'h8D0C_0004, 0, 0, 2'b11, 32'd0, 26'd0, 32'hFFFF_FFFF);
        // sequential from the top of the address space wraps to 0
        fetch_one(32'hFFFF_FFFC, 32'h3C01_1234, 1, 1, 2'b00, 32'd0, 26'd0, 32'd0);
        // jump with all-ones index from pc+4=4: 0x0FFF_FFFC
        fetch_one(32'h0000_0000, 32'h0BFF_FFFF, 0, 0, 2'b10, 32'd0, 26'h3FF_FFFF, 32'd0);

        // reset while the request for 0x0FFF_FFFC is outstanding
        exp_q.push_back('{32'h0FFF_FFFC, 32'h1111_1111});
        tick();
        #2;
        i_rst_n = 1'b0;
        tick();
        tick();
        // a late ack arriving while idle after release must be ignored
        i_imem_ack  = 1'b1;
        i_imem_data = 32'hBAD0_BAD0;
        i_rst_n     = 1'b1;
        fetch_one(32'h0000_0000, 32'h2008_0005, 1, 0, 2'b00, 32'd0, 26'd0, 32'd0);
        fetch_one(32'h0000_0004, 32'h2009_0001, 0, 1, 2'b00, 32'd0, 26'd0, 32'd0);
        done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/single_fetch_unit.md
# single_fetch_unit

Instruction-fetch front end for the single-cycle CPU. Holds the program counter, issues one read per instruction to instruction memory over a req/ack handshake, and presents the fetched instruction with a valid flag. When the datapath consumes that instruction, the unit selects the next PC from PC+4, branch, jump or register target.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst_n  input  1  reset; asynchronous, active-low.
- i_stall  input  1  datapath not ready; holds the presented instruction.
- i_pc_sel  input  2  next-PC source.
  - 00: PC+4.
  - 01: branch.
  - 10: jump.
  - 11: register (jr).
- i_branch_off  input  32  sign-extended word offset for branches.
- i_jump_idx  input  26  jump target word index.
- i_jr_addr  input  32  register jump target.
- o_imem_req  output  1  read request to instruction memory.
- o_imem_addr  output  32  read address; always equals current PC.
- i_imem_ack  input  1  read data valid this cycle.
- i_imem_data  input  32  instruction word, sampled when req && ack.
- o_pc  output  32  PC of the instruction being fetched or presented.
- o_pc_plus4  output  32  o_pc + 4, modulo 2^32.
- o_instr  output  32  fetched instruction (registered).
- o_instr_valid  output  1  o_instr is valid for the datapath.

## Operation
- Registers: pc, state, o_instr. o_imem_addr = o_pc = pc; o_pc_plus4 = pc + 4, combinational, wraps mod 2^32.
- FSM states:
  - S_IDLE: reset state. req=0, valid=0. Goes to S_REQ on the first clock edge after i_rst_n rises.
  - S_REQ: req=1, valid=0. If i_imem_ack is high at the edge: o_instr <= i_imem_data, go to S_VALID. Otherwise stay in S_REQ; req stays high and the address stays stable.
  - S_VALID: req=0, valid=1.
    - If i_stall is high: stay in S_VALID; pc and o_instr hold.
    - If i_stall is low (retire edge): pc <= next_pc, go to S_REQ.
- next_pc is evaluated only at the retire edge. i_pc_sel, i_branch_off, i_jump_idx and i_jr_addr are don't-care at all other times.
  - 00: pc + 4.
  - 01: pc + 4 + (i_branch_off << 2). 32-bit add; overflow wraps.
  - 10: {pc_plus4[31:28], i_jump_idx, 2'b00}.
  - 11: {i_jr_addr[31:2], 2'b00}. Low two bits are forced to 0.
- Outputs are driven only by state; no output depends combinationally on i_imem_ack or i_stall.
- i_imem_ack is ignored in S_IDLE and S_VALID. i_stall is ignored in S_IDLE and S_REQ.
- Reset values: pc=RESET_PC, state=S_IDLE, o_instr=0, o_imem_req=0, o_instr_valid=0, o_imem_addr=RESET_PC, o_pc_plus4=RESET_PC+4.
- Reset mid-operation (including S_REQ with an outstanding request) aborts immediately. An ack that arrives after reset is released, while the unit is in S_IDLE, is ignored.

## Timing
- Edge 1 after reset release: enter S_REQ; req rises.
- Zero-wait memory (ack in the first req cycle): instruction is valid on the next cycle. Throughput is one instruction per 2 cycles with no stall.
- Each wait cycle from memory adds one cycle. Each stall cycle adds one cycle.
- Fetch latency from a retire edge to the new o_instr_valid is 1 + (cycles until ack) cycles.
- New pc appears on o_imem_addr in the same cycle that req rises.

## Test plan
- Reset and first fetch:
  - Stimulus: RESET_PC=0, hold i_rst_n low 3 cycles, then release; ack with data 0x2008_0005 in the first S_REQ cycle.
  - Response: during reset req=0, valid=0, pc=0. Req rises 1 cycle after release with addr=0. Next cycle valid=1, o_instr=0x2008_0005.
- Sequential run:
  - Stimulus: sel=00, no stall, zero-wait memory, 4 instructions.
  - Response: addresses 0, 4, 8, 0xC. valid pulses every 2nd cycle. o_pc_plus4 equals o_pc+4.
- Redirects:
  - Stimulus and response at each retire edge:
    - pc=0x10, sel=01, off=0xFFFF_FFFE: next addr 0x0C.
    - pc=0x9000_0000, sel=10, idx=0x000_0040: next addr 0x9000_0100.
    - sel=11, jr=0x0000_0207: next addr 0x204.
- Handshake and stall:
  - Stimulus: ack withheld for 3 req cycles; then i_stall held 2 cycles while valid.
  - Response: req stays high with a stable addr for 4 cycles. Valid and o_instr hold through the stall. Inputs selecting a next PC that change during the stall have no effect until the stall drops.
- Wrap and mid-fetch reset:
  - Stimulus: pc=0xFFFF_FFFC with sel=00.
  - Response: next addr 0x0000_0000.
  - Stimulus: assert reset while in S_REQ, then ack after reset release.
  - Response: the unit returns to S_IDLE asynchronously. The late ack is ignored and the refetch starts at RESET_PC.
